// File: rtl/softmax_norm.sv
// Row-wise softmax normalizer: buffers one row of UQ3.6 exponents, sums them,
// then divides each element by the sum and emits UQ0.8 probabilities under credit flow control.
module softmax_norm #(
  parameter int ROW_LEN = 8,
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [8:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       credit_return
);

  localparam int IDX_W = $clog2(ROW_LEN);
  localparam int SUM_W = 9 + IDX_W;
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [8:0]       row_buf [ROW_LEN];
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] sum;
  logic [SUM_W:0]   rem;
  logic [8:0]       quot;
  logic [3:0]       step;
  logic [3:0]       credit_cnt;
  logic [3:0]       credit_next;

  logic             accept;
  logic             emit;
  logic             last_elem;
  logic             send_next;
  logic             q_bit;
  logic [SUM_W:0]   rem_src;
  logic [SUM_W-1:0] rem_diff;
  logic [8:0]       quot_next;
  logic [8:0]       q_final;

  // A quotient of 256 only arises when the element equals the sum; clamp to the UQ0.8 maximum.
  function automatic logic [7:0] sat_prob(input logic [8:0] q, input logic sum_zero);
    logic [7:0] r;
    if (sum_zero) begin
      r = 8'd0;
    end else if (q[8]) begin
      r = 8'd255;
    end else begin
      r = q[7:0];
    end
    return r;
  endfunction

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid & in_ready;
  assign emit      = (state == OUT) & out_valid;
  assign last_elem = (idx == LAST_IDX);

  // One restoring-division step; the first step seeds the remainder from the buffered element.
  always_comb begin
    rem_src   = (step == 4'd0) ? {{(IDX_W + 1){1'b0}}, row_buf[idx]} : rem;
    q_bit     = (rem_src >= {1'b0, sum});
    rem_diff  = q_bit ? SUM_W'(rem_src - {1'b0, sum}) : rem_src[SUM_W-1:0];
    quot_next = {quot[7:0], q_bit};
    q_final   = (state == DIV) ? quot_next : quot;
  end

  // Credit counter next value: simultaneous use and return cancel, returns saturate at the maximum.
  always_comb begin
    credit_next = credit_cnt;
    case ({out_valid, credit_return})
      2'b10:   credit_next = credit_cnt - 4'd1;
      2'b01:   credit_next = (credit_cnt == CRED_MAX) ? credit_cnt : credit_cnt + 4'd1;
      default: credit_next = credit_cnt;
    endcase
  end

  // Next-state decode and launch decision for the registered output pulse.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM: begin
        if (accept && last_elem) begin
          state_next = DIV;
        end else begin
          state_next = ACCUM;
        end
      end
      DIV: begin
        if (step == 4'd8) begin
          state_next = OUT;
        end else begin
          state_next = DIV;
        end
      end
      OUT: begin
        if (out_valid) begin
          state_next = last_elem ? ACCUM : DIV;
        end else begin
          state_next = OUT;
        end
      end
      default: state_next = ACCUM;
    endcase
    send_next = (state_next == OUT) && (credit_next != 4'd0);
  end

  // State and credit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      credit_cnt <= CRED_MAX;
    end else begin
      state      <= state_next;
      credit_cnt <= credit_next;
    end
  end

  // Row buffer, running sum, element index and divider datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        row_buf[i] <= 9'd0;
      end
      idx  <= '0;
      sum  <= '0;
      rem  <= '0;
      quot <= 9'd0;
      step <= 4'd0;
    end else begin
      if (accept) begin
        row_buf[idx] <= in_data;
        sum          <= sum + SUM_W'(in_data);
        idx          <= idx + IDX_W'(1);
      end else if (state == DIV) begin
        rem  <= {rem_diff, 1'b0};
        quot <= quot_next;
        step <= (step == 4'd8) ? 4'd0 : step + 4'd1;
      end else if (emit) begin
        idx <= idx + IDX_W'(1);
        if (last_elem) begin
          sum <= '0;
        end else begin
          sum <= sum;
        end
      end else begin
        idx <= idx;
      end
    end
  end

  // Registered output beat; data is held between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= send_next;
      if (send_next) begin
        out_data <= sat_prob(q_final, (sum == '0));
        out_last <= last_elem;
      end else begin
        out_data <= out_data;
        out_last <= out_last;
      end
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// Scoreboard bench for softmax_norm (ROW_LEN=4, CREDITS=2): directed rows with
// hand-computed probabilities, checked by an independent output monitor.
module tb_softmax_norm;
  localparam int ROW_LEN = 4;
  localparam int CREDITS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = 9'd0;
  logic       credit_return = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc_cyc = 0;
  int first_out_cyc = -1;
  int exp_q[$];
  bit auto_ret = 1'b0;
  bit man_ret = 1'b0;

  softmax_norm #(.ROW_LEN(ROW_LEN), .CREDITS(CREDITS)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .credit_return(credit_return)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    credit_return = (auto_ret && out_valid) || man_ret;
  end

  // Output monitor: pops the scoreboard on every pulse.
  always @(negedge clk) begin
    if (out_valid) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0d required=none", out_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e & 255));
        check("out_last", 32'(out_last), 32'(e >> 8));
      end
    end
  end

  task automatic expect_row(input int a, input int b, input int c, input int d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d | 256);
  endtask

  task automatic send_beat(input int v);
    int n;
    bit acc;
    in_valid = 1'b1;
    in_data  = 9'(v);
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      last_acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", 32'(n), 32'(0));
  endtask

  // Leaves in_valid high; caller decides when to drop it.
  task automatic send_row(input int a, input int b, input int c, input int d);
    send_beat(a);
    send_beat(b);
    send_beat(c);
    send_beat(d);
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic pulse_return();
    @(posedge clk);
    #1 man_ret = 1'b1;
    @(posedge clk);
    #1 man_ret = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_out_data"}, 32'(out_data), 32'(0));
    check({tag, "_out_last"}, 32'(out_last), 32'(0));
    check({tag, "_credit"}, 32'(dut.credit_cnt), 32'(CREDITS));
    check({tag, "_sum"}, 32'(dut.sum), 32'(0));
    check({tag, "_idx"}, 32'(dut.idx), 32'(0));
  endtask

  initial begin
    int acc0;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    auto_ret = 1'b1;

    // Normal row and first-output latency.
    expect_row(128, 64, 32, 32);
    first_out_cyc = -1;
    send_row(100, 50, 25, 25);
    in_valid = 1'b0;
    wait_out(200);
    check("first_latency", 32'(first_out_cyc - last_acc_cyc), 32'(10));

    // Uniform row.
    expect_row(64, 64, 64, 64);
    send_row(64, 64, 64, 64);
    in_valid = 1'b0;
    wait_out(200);

    // Saturation, then an all-zero row.
    expect_row(255, 0, 0, 0);
    send_row(448, 0, 0, 0);
    in_valid = 1'b0;
    wait_out(200);
    expect_row(0, 0, 0, 0);
    send_row(0, 0, 0, 0);
    in_valid = 1'b0;
    wait_out(200);
    check("zero_row_ready", 32'(in_ready), 32'(1));

    // Credit stall with no returns.
    check("credit_full", 32'(dut.credit_cnt), 32'(CREDITS));
    auto_ret = 1'b0;
    expect_row(128, 64, 32, 32);
    send_row(100, 50, 25, 25);
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (30) @(posedge clk);
    #1;
    check("stall_pending", 32'(exp_q.size()), 32'(2));
    check("stall_credit", 32'(dut.credit_cnt), 32'(0));
    check("stall_valid", 32'(out_valid), 32'(0));
    auto_ret = 1'b1;
    pulse_return();
    check("resume_next_cycle", 32'(out_valid), 32'(1));
    @(posedge clk);
    #1;
    check("coincident_at_one", 32'(dut.credit_cnt), 32'(1));
    wait_out(200);
    auto_ret = 1'b0;
    pulse_return();
    check("return_to_max", 32'(dut.credit_cnt), 32'(CREDITS));
    pulse_return();
    check("return_saturates", 32'(dut.credit_cnt), 32'(CREDITS));
    auto_ret = 1'b1;

    // in_valid held through DIV/OUT must not consume extra beats.
    expect_row(64, 64, 64, 64);
    acc0 = acc_cnt;
    send_row(64, 64, 64, 64);
    in_data = 9'd511;
    repeat (35) @(posedge clk);
    #1 in_valid = 1'b0;
    check("backpressure_beats", 32'(acc_cnt - acc0), 32'(4));
    wait_out(200);
    expect_row(128, 64, 32, 32);
    send_row(100, 50, 25, 25);
    in_valid = 1'b0;
    wait_out(200);

    // Reset in the middle of DIV discards the row.
    send_row(100, 100, 100, 100);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_valid", 32'(out_valid), 32'(0));
    expect_row(64, 64, 64, 64);
    send_row(64, 64, 64, 64);
    in_valid = 1'b0;
    wait_out(200);

    repeat (5) @(posedge clk);
    #1;
    check("final_empty", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/softmax_norm.md
# softmax_norm

Row-wise softmax normalizer that sits directly downstream of the exponent unit. It buffers one row of UQ3.6 exponent values, accumulates their sum, and divides each element by that sum with a serial restoring divider. It then emits UQ0.8 probabilities to the next stage under credit-based flow control. The block completes the softmax of the attention engine: mac → exp → softmax_norm → value-weighting stage.

## Interface
Parameters:
- `ROW_LEN`, default 8: elements per row; power of two, 2..64.
- `CREDITS`, default 4: initial and maximum downstream credits, 1..15.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_data`  in  9  exponent result, UQ3.6 (0..511 codes).
- `in_ready`  out  1  block accepts a beat this cycle.
- `out_valid`  out  1  one-cycle pulse per emitted probability; consumes one credit.
- `out_data`  out  8  probability, UQ0.8.
- `out_last`  out  1  high with the last element of a row.
- `credit_return`  in  1  downstream returns one credit per cycle high.

## Operation
- Sum register width is SUM_W = 9 + log2(ROW_LEN). The maximum sum, 511·ROW_LEN, never overflows.
- Row buffer is ROW_LEN × 9 registers, written in arrival order and indexed by a log2(ROW_LEN)-bit counter.
- FSM states:
  - ACCUM (reset state):
    - `in_ready` = 1.
    - On `in_valid & in_ready`: write `buf[idx]`, add `in_data` to the sum, increment `idx`.
    - When the ROW_LEN-th beat is accepted, go to DIV with `idx` = 0.
  - DIV:
    - `in_ready` = 0.
    - Computes q = floor(buf[idx]·256 / S) with a restoring divider: numerator {buf[idx], 8'b0}, one quotient bit per cycle, 9 quotient bits.
    - Takes exactly 9 cycles, then goes to OUT.
  - OUT:
    - `in_ready` = 0.
    - If `credit_cnt` > 0: `out_valid` = 1 for one cycle.
      - `out_data` = (S == 0) ? 0 : min(q, 255). q = 256 occurs only when the element equals S; it saturates to 255.
      - `out_last` = (`idx` == ROW_LEN-1).
      - Then `idx` increments. If the element was the last, clear the sum and `idx` and go to ACCUM; otherwise go to DIV.
    - If `credit_cnt` == 0: hold in OUT with `out_valid` = 0 and the quotient retained.
- Credit counter, 4 bits:
  - Reset value is CREDITS.
  - Decrements on `out_valid`, increments on `credit_return`.
  - Both in the same cycle: unchanged.
  - `credit_return` while the count equals CREDITS is ignored (saturates).
- S == 0 (all-zero row): divider still runs its 9 cycles; output is forced to 0 and the block never hangs.
- Input beats presented while `in_ready` = 0 are not consumed; upstream holds them.

## Timing
- Reset values: `in_ready` = 1 (state ACCUM), `out_valid` = 0, `out_data` = 0, `out_last` = 0, sum = 0, `idx` = 0, `credit_cnt` = CREDITS.
- `in_ready` is decoded from state only, with no combinational path from `in_valid`.
- `out_valid`, `out_data` and `out_last` are registered.
- Minimum row accept time is ROW_LEN cycles of back-to-back `in_valid`.
- Per element with credit available: 9 DIV cycles + 1 OUT cycle = 10 cycles.
- First `out_valid` comes 10 cycles after the cycle in which the last input beat is accepted.
- Minimum row period is ROW_LEN + 10·ROW_LEN cycles. No overlap between rows.
- A credit returned in cycle t is usable for an `out_valid` in cycle t+1.
- Reset asserted in any state:
  - Takes effect at the next edge.
  - The partial row is discarded and credits are restored to CREDITS.
  - No `out_valid` pulse occurs in the cycle after reset.

## Test plan
- Normal row (ROW_LEN=4, ample credits): inputs 100, 50, 25, 25 (S=200) → outputs 128, 64, 32, 32; `out_last` only on the 4th; first output 10 cycles after the last accept.
- Uniform row: inputs 4×64 → outputs 64, 64, 64, 64.
- Saturation and zero row:
  - Inputs 448, 0, 0, 0 → outputs 255, 0, 0, 0.
  - Next row 0, 0, 0, 0 → outputs 0, 0, 0, 0, then `in_ready` = 1 again.
- Credit stall: CREDITS=2, no returns → exactly 2 `out_valid` pulses, then OUT holds. Pulse `credit_return` once → 3rd output appears on the next cycle with its correct value.
- Credit edge cases:
  - `credit_return` coincident with `out_valid` at count 1 → count stays 1.
  - `credit_return` at count CREDITS → count stays CREDITS.
- Backpressure and reset:
  - `in_valid` held high during DIV/OUT → no extra beats consumed; the next row starts cleanly.
  - `rst` asserted mid-DIV → all outputs return to reset values. A following 4×64 row yields 64×4 with full credits.
